// File: rtl/clk_div_pkg.sv
// Shared constants and types for the multi-channel clock/tick divider.
package clk_div_pkg;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

    localparam int CNT_W_DEF = 23;
    localparam int DIV_1HZ   = 5000000;
    localparam int DIV_SCAN  = 250000;

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, shadowed divisor/mode and registered outputs.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int   CNT_W    = CNT_W_DEF,
    parameter int   DEF_DIV  = DIV_1HZ,
    parameter logic DEF_MODE = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] wr_div_i,
    input  logic             wr_mode_i,
    output logic             pend_o,
    output logic             clk_out_o,
    output logic             tick_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] sdiv_q, sdiv_d;
    mode_e            mode_q, mode_d;
    mode_e            smode_q, smode_d;
    logic             pend_q, pend_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             idle;
    logic             terminal;
    logic             apply;

    // div == 0 is decoded separately so the div-1 compare can never wrap.
    assign idle     = (div_q == '0);
    assign terminal = en_i && !idle && (cnt_q == div_q - CNT_W'(1));
    assign apply    = pend_q && (terminal || !en_i || idle);

    always_comb begin
        cnt_d     = cnt_q;
        div_d     = div_q;
        mode_d    = mode_q;
        sdiv_d    = sdiv_q;
        smode_d   = smode_q;
        pend_d    = pend_q;
        clk_out_d = clk_out_q;
        tick_d    = 1'b0;

        if (apply) begin
            div_d  = sdiv_q;
            mode_d = smode_q;
            pend_d = 1'b0;
        end
        // A write coincident with an apply lands in the shadow after the old value moved out.
        if (wr_i) begin
            sdiv_d  = wr_div_i;
            smode_d = mode_e'(wr_mode_i);
            pend_d  = 1'b1;
        end

        if (!en_i || idle) begin
            cnt_d     = '0;
            clk_out_d = 1'b0;
        end else if (terminal) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            if (mode_d == MODE_PULSE || mode_q == MODE_PULSE) begin
                clk_out_d = 1'b1;
            end else begin
                clk_out_d = ~clk_out_q;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (mode_q == MODE_PULSE) begin
                clk_out_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            div_q     <= CNT_W'(DEF_DIV);
            mode_q    <= mode_e'(DEF_MODE);
            sdiv_q    <= CNT_W'(DEF_DIV);
            smode_q   <= mode_e'(DEF_MODE);
            pend_q    <= 1'b0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            mode_q    <= mode_d;
            sdiv_q    <= sdiv_d;
            smode_q   <= smode_d;
            pend_q    <= pend_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign pend_o    = pend_q;
    assign clk_out_o = clk_out_q;
    assign tick_o    = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock/tick generator; decodes the config channel select per channel.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int   NUM_CH   = 4,
    parameter int   CNT_W    = CNT_W_DEF,
    parameter int   DEF_DIV  = DIV_1HZ,
    parameter logic DEF_MODE = 1'b0,
    localparam int  CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_CH-1:0] en_i,
    input  logic              cfg_wr_i,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [CNT_W-1:0]  cfg_div_i,
    input  logic              cfg_mode_i,
    output logic [NUM_CH-1:0] cfg_pend_o,
    output logic [NUM_CH-1:0] clk_out_o,
    output logic [NUM_CH-1:0] tick_o
);

    logic [NUM_CH-1:0] wr_en;

    // Selects >= NUM_CH match no channel and are silently dropped.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign wr_en[g] = cfg_wr_i && (cfg_ch_i == CH_W'(g));

        clk_div_ch #(
            .CNT_W    (CNT_W),
            .DEF_DIV  (DEF_DIV),
            .DEF_MODE (DEF_MODE)
        ) u_ch (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .en_i      (en_i[g]),
            .wr_i      (wr_en[g]),
            .wr_div_i  (cfg_div_i),
            .wr_mode_i (cfg_mode_i),
            .pend_o    (cfg_pend_o[g]),
            .clk_out_o (clk_out_o[g]),
            .tick_o    (tick_o[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: three channels, divisor 4 at reset, 8-bit counters.
module tb_clk_div_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] en;
    logic       cfg_wr;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic       cfg_mode;
    logic [2:0] cfg_pend;
    logic [2:0] clk_out;
    logic [2:0] tick;

    int passed = 0;
    int total  = 0;

    clk_div_multi #(
        .NUM_CH   (3),
        .CNT_W    (8),
        .DEF_DIV  (4),
        .DEF_MODE (1'b0)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .cfg_wr_i   (cfg_wr),
        .cfg_ch_i   (cfg_ch),
        .cfg_div_i  (cfg_div),
        .cfg_mode_i (cfg_mode),
        .cfg_pend_o (cfg_pend),
        .clk_out_o  (clk_out),
        .tick_o     (tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [2:0] en;
        logic       wr;
        logic [1:0] ch;
        logic [7:0] div;
        logic       mode;
        logic [2:0] e_tick;
        logic [2:0] e_clk;
        logic [2:0] e_pend;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // Drive one cycle of inputs, clock once, then compare all three output vectors.
    task automatic cyc(input string name, input logic r, input logic [2:0] e, input logic w,
                       input logic [1:0] c, input logic [7:0] d, input logic m,
                       input logic [2:0] et, input logic [2:0] ec, input logic [2:0] ep);
        rst = r; en = e; cfg_wr = w; cfg_ch = c; cfg_div = d; cfg_mode = m;
        @(posedge clk);
        #1;
        check({name, " tick"}, tick, et);
        check({name, " clk_out"}, clk_out, ec);
        check({name, " pend"}, cfg_pend, ep);
    endtask

    initial begin
        rst = 1'b1; en = '0; cfg_wr = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;

        // Reset defaults on ch0/ch1, live change of ch1 to div 3 at cnt=1, out-of-range write.
        //            rst   en      wr    ch     div    mode  tick    clk     pend
        vecs[0]  = '{1'b1, 3'b000, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000};
        vecs[1]  = '{1'b0, 3'b011, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000};
        vecs[2]  = '{1'b0, 3'b011, 1'b1, 2'd1, 8'd3, 1'b0, 3'b000, 3'b000, 3'b010};
        vecs[3]  = '{1'b0, 3'b011, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b010};
        vecs[4]  = '{1'b0, 3'b011, 1'b0, 2'd0, 8'd0, 1'b0, 3'b011, 3'b011, 3'b000};
        vecs[5]  = '{1'b0, 3'b011, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b011, 3'b000};
        vecs[6]  = '{1'b0, 3'b011, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b011, 3'b000};
        vecs[7]  = '{1'b0, 3'b011, 1'b0, 2'd0, 8'd0, 1'b0, 3'b010, 3'b001, 3'b000};
        vecs[8]  = '{1'b0, 3'b011, 1'b0, 2'd0, 8'd0, 1'b0, 3'b001, 3'b000, 3'b000};
        vecs[9]  = '{1'b0, 3'b011, 1'b1, 2'd3, 8'd7, 1'b1, 3'b000, 3'b000, 3'b000};
        vecs[10] = '{1'b0, 3'b011, 1'b0, 2'd0, 8'd0, 1'b0, 3'b010, 3'b010, 3'b000};
        vecs[11] = '{1'b0, 3'b011, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b010, 3'b000};
        vecs[12] = '{1'b0, 3'b011, 1'b0, 2'd0, 8'd0, 1'b0, 3'b001, 3'b011, 3'b000};

        #2;
        for (int i = 0; i < 13; i++) begin
            cyc($sformatf("vec%0d", i), vecs[i].rst, vecs[i].en, vecs[i].wr, vecs[i].ch,
                vecs[i].div, vecs[i].mode, vecs[i].e_tick, vecs[i].e_clk, vecs[i].e_pend);
        end

        // Pulse mode with div 1 on ch2, then div 0 idles it, then div 2 restarts from cnt 0.
        cyc("B rst",     1'b1, 3'b000, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000);
        cyc("B wr",      1'b0, 3'b000, 1'b1, 2'd2, 8'd1, 1'b1, 3'b000, 3'b000, 3'b100);
        cyc("B apply",   1'b0, 3'b000, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000);
        for (int i = 0; i < 4; i++)
            cyc("B div1",  1'b0, 3'b100, 1'b0, 2'd0, 8'd0, 1'b0, 3'b100, 3'b100, 3'b000);
        cyc("B wr0",     1'b0, 3'b100, 1'b1, 2'd2, 8'd0, 1'b1, 3'b100, 3'b100, 3'b100);
        cyc("B app0",    1'b0, 3'b100, 1'b0, 2'd0, 8'd0, 1'b0, 3'b100, 3'b100, 3'b000);
        for (int i = 0; i < 4; i++)
            cyc("B div0",  1'b0, 3'b100, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000);
        cyc("B wr2",     1'b0, 3'b100, 1'b1, 2'd2, 8'd2, 1'b0, 3'b000, 3'b000, 3'b100);
        cyc("B app2",    1'b0, 3'b100, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000);
        cyc("B run1",    1'b0, 3'b100, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000);
        cyc("B run2",    1'b0, 3'b100, 1'b0, 2'd0, 8'd0, 1'b0, 3'b100, 3'b100, 3'b000);

        // Enable gating on ch0: drop mid-period, reprogram while disabled, re-enable.
        cyc("C rst",     1'b1, 3'b000, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000);
        for (int i = 0; i < 3; i++)
            cyc("C cnt",   1'b0, 3'b001, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000);
        cyc("C term",    1'b0, 3'b001, 1'b0, 2'd0, 8'd0, 1'b0, 3'b001, 3'b001, 3'b000);
        cyc("C mid",     1'b0, 3'b001, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b001, 3'b000);
        cyc("C off",     1'b0, 3'b000, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000);
        cyc("C wr",      1'b0, 3'b000, 1'b1, 2'd0, 8'd2, 1'b0, 3'b000, 3'b000, 3'b001);
        cyc("C apply",   1'b0, 3'b000, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000);
        cyc("C on1",     1'b0, 3'b001, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000);
        cyc("C on2",     1'b0, 3'b001, 1'b0, 2'd0, 8'd0, 1'b0, 3'b001, 3'b001, 3'b000);

        // Collisions on ch1: double write, then a write coincident with the terminal.
        cyc("D rst",     1'b1, 3'b000, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000);
        cyc("D c1",      1'b0, 3'b010, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000);
        cyc("D wr6",     1'b0, 3'b010, 1'b1, 2'd1, 8'd6, 1'b0, 3'b000, 3'b000, 3'b010);
        cyc("D wr5",     1'b0, 3'b010, 1'b1, 2'd1, 8'd5, 1'b0, 3'b000, 3'b000, 3'b010);
        cyc("D wr2term", 1'b0, 3'b010, 1'b1, 2'd1, 8'd2, 1'b0, 3'b010, 3'b010, 3'b010);
        for (int i = 0; i < 4; i++)
            cyc("D div5",  1'b0, 3'b010, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b010, 3'b010);
        cyc("D term5",   1'b0, 3'b010, 1'b0, 2'd0, 8'd0, 1'b0, 3'b010, 3'b000, 3'b000);
        cyc("D div2a",   1'b0, 3'b010, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000);
        cyc("D term2",   1'b0, 3'b010, 1'b0, 2'd0, 8'd0, 1'b0, 3'b010, 3'b010, 3'b000);

        // Reset with a pending config and clk_out high, then the default divisor returns.
        cyc("E wr7",     1'b0, 3'b010, 1'b1, 2'd1, 8'd7, 1'b0, 3'b000, 3'b010, 3'b010);
        cyc("E rst",     1'b1, 3'b010, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000);
        for (int i = 0; i < 3; i++)
            cyc("E cnt",   1'b0, 3'b010, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000);
        cyc("E term4",   1'b0, 3'b010, 1'b0, 2'd0, 8'd0, 1'b0, 3'b010, 3'b010, 3'b000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Parametrised multi-channel clock/tick generator for the stopwatch and display datapath. Each of `NUM_CH` channels divides `Clk` by a runtime-programmable divisor and produces either a 50 % toggled clock or a one-cycle tick pulse. Divisor and mode updates are shadowed and take effect only at a period boundary, so outputs never glitch or produce short periods. It replaces the fixed single-output 1 Hz divider.

## Interface
- `NUM_CH`, 4: number of independent channels (1..8).
- `CNT_W`, 23: counter and divisor width.
- `DEF_DIV`, 5000000: divisor loaded into every channel at reset.
- `DEF_MODE`, 0: mode loaded at reset (0 = toggle, 1 = pulse).

- `Clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  NUM_CH: per-channel run enable.
- `cfg_wr`  in  1: single-cycle configuration write strobe.
- `cfg_ch`  in  $clog2(NUM_CH) (min 1): target channel.
- `cfg_div`  in  CNT_W: new divisor.
- `cfg_mode`  in  1: new mode.
- `cfg_pend`  out  NUM_CH: shadow holds an unapplied config.
- `clk_out`  out  NUM_CH: divided clock (toggle mode) or tick copy (pulse mode).
- `tick`  out  NUM_CH: one-cycle pulse at each terminal count.

## Operation
- Per channel: active `div`/`mode`, shadow `div`/`mode` with `pend` flag, counter `cnt`.
- Reset: `cnt`=0, active=shadow=`DEF_DIV`/`DEF_MODE`, `pend`=0, `clk_out`=0, `tick`=0.
- Running (`en`=1, `div`≠0): `cnt` counts 0..`div`-1. Terminal = (`cnt`==`div`-1). On terminal, `cnt`←0, `tick`←1 for one cycle.
  - Toggle mode: `clk_out` inverts on each terminal, giving period 2·`div` cycles.
  - Pulse mode: `clk_out` equals `tick`.
- `div`=0: channel idle. `cnt` held at 0, `clk_out`=0, `tick`=0.
- `div`=1: terminal every cycle. Toggle gives Clk/2; pulse gives `tick` constantly high.
- Config write: when `cfg_wr`=1 and `cfg_ch`<NUM_CH, the shadow is loaded and `pend` is set. Last write wins if already pending. Writes with `cfg_ch`≥NUM_CH are ignored.
- Shadow application, with `pend` cleared in the same cycle:
  - at a terminal cycle when running, or
  - on any cycle with `en`=0 or active `div`=0.
- Terminal and `cfg_wr` to the same channel in the same cycle: the terminal applies the old shadow if it was pending. The new write lands in the shadow and applies at the next boundary.
- Mode switch at a boundary: `clk_out` follows the new mode from that edge. Toggle→pulse gives `clk_out`=`tick`. Pulse→toggle gives `clk_out` toggled from 0.
- `en` falling: next edge `cnt`←0, `clk_out`←0, `tick`←0.
- `en` rising: the first terminal occurs `div` cycles later.
- Reset overrides everything, including mid-period and pending configs.

## Timing
- All outputs are registered. `tick` and the `clk_out` edge appear on the edge after the terminal `cnt` value is present.
- Write latency: `cfg_pend` goes high one cycle after `cfg_wr`.
- Apply latency: an idle or disabled channel applies the new value one cycle after `pend` rises. A running channel applies it at the next terminal. The first period with the new divisor then starts immediately, so there are no short periods.
- Counter arithmetic is `CNT_W` unsigned. The compare uses `div`-1 and never wraps because `div`=0 is decoded separately.

## Structure
- Shared package `clk_div_pkg`: `MODE_TOGGLE`=1'b0, `MODE_PULSE`=1'b1, default `CNT_W`, and the default divisor constants (`DIV_1HZ`=5000000, `DIV_SCAN`=250000).
- Sub-module `clk_div_ch`: one channel (counter, shadow, apply logic, outputs), instantiated `NUM_CH` times in a generate loop.
- The top level only decodes `cfg_ch` into per-channel write enables.

## Test plan
- Reset defaults: release `rst` with `DEF_DIV`=4, toggle, `en`=1 → `clk_out`[0] toggles every 4 cycles (period 8), `tick` high once per 4 cycles, `cfg_pend`=0.
- Live divisor change: write `cfg_div`=3 to ch1 mid-period at `cnt`=1 of `div`=4 → `cfg_pend`[1]=1 until terminal; current period still 4 cycles, subsequent periods 3.
- Pulse and `div`=1: ch2 pulse mode, `div`=1 → `tick`[2] and `clk_out`[2] continuously 1. Then `div`=0 → both 0 and `cnt` held at 0.
- Enable gating: drop `en`[0] mid-period → next edge `clk_out`=0. Write `div`=2 while disabled → `pend` clears one cycle later. Re-enable → first `tick` after 2 cycles.
- Collisions: `cfg_wr` coincident with a terminal, a double write before the boundary, and `cfg_ch`=NUM_CH → last write wins, it applies at the following terminal, and the out-of-range write has no effect.
- Reset mid-operation: assert `rst` with pending configs and `clk_out`=1 → all outputs 0, `DEF_DIV` restored, `cfg_pend`=0.
